x25519_addsub_pipe: RTL and testbench
=====================================

// Module: x25519_addsub_pipe
// PURPOSE
//   Parametrised, limb-pipelined modular add/subtract unit for the X25519 datapath; next generation of the single-cycle
//   subtractor. Per-operation mode selects a+b or a-b+BIAS (BIAS = 2p keeps results non-negative, unreduced).
//   Carry ripples one limb per stage, so wide operands close timing; one op accepted per clock; a tag follows each op.
// PARAMETERS
//   WIDTH       264        operand/result width in bits; must be >= 257
//   LIMB_WIDTH  66         bits per pipeline stage; WIDTH % LIMB_WIDTH == 0; NUM_LIMBS = WIDTH/LIMB_WIDTH
//   BIAS        2^256-38   constant (2p) added in subtract mode, zero-extended to WIDTH
//   TAG_WIDTH   8          width of the opaque tag carried alongside each op
// PORTS
//   clk        in   1          clock; all logic on posedge
//   rst_n      in   1          synchronous active-low reset
//   en         in   1          start op this cycle; no backpressure, accepted every cycle
//   mode       in   1          0 = add (a+b), 1 = subtract (a-b+BIAS)
//   a          in   WIDTH      first operand
//   b          in   WIDTH      second operand
//   tag_in     in   TAG_WIDTH  tag captured with the op
//   out_valid  out  1          result valid this cycle
//   out        out  WIDTH      result
//   tag_out    out  TAG_WIDTH  tag of the op whose result is on out
// BEHAVIOUR
//   - Reset: one clk and reset; reset is synchronous and active-low. While rst_n low at posedge, every pipeline
//     register (valid, data, carry, tag) clears to 0. Thus out_valid=0, out=0, tag_out=0 from the next cycle on.
//   - Reset mid-stream discards all in-flight ops; none ever emerges. en sampled in a reset cycle is ignored.
//   - Arithmetic: add: out = (a + b) mod 2^WIDTH. sub: out = (a + ~b + 1 + BIAS) mod 2^WIDTH, i.e. a-b+BIAS.
//     Implemented as a three-operand sum: a, b or ~b, and BIAS or 0. Sub injects +1 as carry-in to limb 0.
//     No overflow/underflow flag; the caller keeps a,b < 2^256 so results fit in 257 bits.
//   - Pipeline: stage k (k=0..NUM_LIMBS-1) adds limb k of the three operands plus the carry from stage k-1.
//     The carry is up to 2 bits, since three operands are summed.
//     Upper operand limbs are skewed forward through registers; completed lower result limbs are deskewed by delay.
//   - Latency: exactly NUM_LIMBS cycles from en-high edge to out_valid-high edge (default 4; NUM_LIMBS=1 -> 1 cycle).
//   - Throughput 1 op/cycle; results in issue order; each valid result held one cycle only, then replaced or dropped.
//   - out/tag_out hold last value while out_valid=0 (no forced zeroing except reset).
//   - en=0 cycles create bubbles; out_valid mirrors en delayed NUM_LIMBS cycles exactly.
// STRUCTURE
//   - Package x25519_pkg: X25519_P, X25519_TWO_P (BIAS default), X25519_WIDTH=264, typedef x25519_mode_t {ADD, SUB}.
//   - Sub-module x25519_limb_adder: registered LIMB_WIDTH-bit 3-input adder, carry_in[1:0] -> sum, carry_out[1:0].
//     Instantiated NUM_LIMBS times by generate; the top holds skew/deskew shift registers, valid and tag pipes.
// TESTING
//   - Sub a=256'hdc21740e..4a516967, b=256'h873d4182..ecff73c6 -> 4 cycles later out_valid=1.
//     out=264'h0154e4328c42e706f8896eedc848d856342e93cb1c59325bba9cf70e5b5d51f57b.
//   - Sub a=b=256'h1234 -> out=264'h00ffff..ffda (=2p). Add a=1, b=2 -> out=3.
//   - Limb carry: add a=2^66-1, b=1 -> out=2^66. Add a=b=2^256-1 -> out=2^257-2 (full ripple).
//   - Streaming: 5 back-to-back ops, alternating mode, tags 0..4, then 2 bubbles, then 1 op.
//     -> results one per cycle in order with matching tags; out_valid low exactly for the bubbles.
//   - Reset mid-stream: drop rst_n for 1 cycle with 3 ops in flight -> out_valid never pulses for them.
//     out=0 and tag_out=0 after reset; next op completes with normal latency.
//   - Param sweep NUM_LIMBS=1 (LIMB_WIDTH=264) and 8 (LIMB_WIDTH=33): the test 1 vector gives the identical result.
//     Latency is 1 and 8 cycles respectively.

Source files
------------

// File: rtl/x25519_pkg.sv
// x25519_pkg
//   Shared constants and types for the X25519 add/subtract datapath.
//   X25519_P      : field prime 2^255 - 19
//   X25519_TWO_P  : 2p = 2^256 - 38. Adding it to a subtraction keeps the
//                   unreduced result non-negative.
//   X25519_WIDTH  : default datapath width. It leaves headroom above 257 bits
//                   and splits evenly into 66-bit limbs.
//   x25519_mode_t : per-operation mode select.
package x25519_pkg;

  localparam int X25519_WIDTH = 264;

  localparam logic [255:0] X25519_P     = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] X25519_TWO_P = X25519_P << 1;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } x25519_mode_t;

endpackage

// File: rtl/x25519_limb_adder.sv
// x25519_limb_adder
//   Registered three-input limb adder. It forms one pipeline stage of the
//   add/subtract unit. Three full limbs plus a carry of up to 3 give at most
//   3*2^LIMB_WIDTH. That value always fits in LIMB_WIDTH + 2 bits, so a 2-bit
//   carry-out is enough.
// Ports
//   clk        : clock, posedge
//   rst_n      : synchronous active-low reset; clears sum and carry_out
//   en         : capture a new sum this cycle; otherwise the registers hold
//   x, y, z    : limb operands
//   carry_in   : 2-bit carry from the previous stage (or the +1 of a subtract)
//   sum        : registered low LIMB_WIDTH bits of the total
//   carry_out  : registered top 2 bits of the total
module x25519_limb_adder
  import x25519_pkg::*;
#(
  parameter int LIMB_WIDTH = 66
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [LIMB_WIDTH-1:0] x,
  input  logic [LIMB_WIDTH-1:0] y,
  input  logic [LIMB_WIDTH-1:0] z,
  input  logic [1:0]            carry_in,
  output logic [LIMB_WIDTH-1:0] sum,
  output logic [1:0]            carry_out
);

  localparam int TW = LIMB_WIDTH + 2;

  logic [TW-1:0] total;

  always_comb begin
    total = TW'(x) + TW'(y) + TW'(z) + TW'(carry_in);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= '0;
    end else if (en) begin
      sum       <= total[LIMB_WIDTH-1:0];
      carry_out <= total[TW-1:LIMB_WIDTH];
    end
  end

endmodule

// File: rtl/x25519_addsub_pipe.sv
// x25519_addsub_pipe
//   Limb-pipelined modular add/subtract unit.
//     mode = ADD : out = (a + b)            mod 2^WIDTH
//     mode = SUB : out = (a + ~b + 1 + BIAS) mod 2^WIDTH   (= a - b + 2p)
//   Stage k adds limb k of (a, b or ~b, BIAS or 0) plus the carry from stage k-1.
//   The skew registers delay the upper operand limbs so they reach their stage
//   together with that stage's carry. The deskew registers delay each finished
//   lower result limb so that all limbs appear on out in the same cycle.
//   The latency is NUM_LIMBS cycles.
// Handshake
//   This is a valid-only stream with no backpressure. An op is accepted on
//   every posedge where en=1 and rst_n=1. out_valid is en delayed by exactly
//   NUM_LIMBS cycles. Each result is presented for a single cycle.
//   out and tag_out hold their last value while out_valid=0.
// Ports
//   clk, rst_n      : clock, synchronous active-low reset (clears every register)
//   en, mode        : issue strobe and operation select (0 add, 1 subtract)
//   a, b            : WIDTH-bit operands
//   tag_in          : opaque tag that travels with the op
//   out_valid, out  : result strobe and result
//   tag_out         : tag of the op whose result is on out
module x25519_addsub_pipe
  import x25519_pkg::*;
#(
  parameter int               WIDTH      = X25519_WIDTH,
  parameter int               LIMB_WIDTH = 66,
  parameter logic [WIDTH-1:0] BIAS       = WIDTH'(X25519_TWO_P),
  parameter int               TAG_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam int NUM_LIMBS = WIDTH / LIMB_WIDTH;
  localparam int LW        = LIMB_WIDTH;

  // Element 0 of each chain is the input side and element NUM_LIMBS is the
  // output side. en_chain[k] is therefore the update enable of stage k.
  logic [NUM_LIMBS-1:0]                valid_q;
  logic [NUM_LIMBS:0]                  en_chain;
  logic [NUM_LIMBS-1:0][TAG_WIDTH-1:0] tag_q;
  logic [NUM_LIMBS:0][TAG_WIDTH-1:0]   tag_chain;
  logic [NUM_LIMBS-1:0][1:0]           carry;
  logic [NUM_LIMBS-1:0][LW-1:0]        res_limbs;
  logic                                unused_carry;

  assign en_chain  = {valid_q, en};
  assign tag_chain = {tag_q, tag_in};
  assign out_valid = en_chain[NUM_LIMBS];
  assign tag_out   = tag_chain[NUM_LIMBS];
  assign out       = res_limbs;

  // The carry out of the top limb falls outside the modulus.
  assign unused_carry = ^carry[NUM_LIMBS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_LIMBS; k++) begin
        valid_q[k] <= en_chain[k];
        // The tag stage moves only with a valid op, so tag_out holds during bubbles.
        if (en_chain[k]) tag_q[k] <= tag_chain[k];
      end
    end
  end

  for (genvar j = 0; j < NUM_LIMBS; j++) begin : g_limb
    logic          mode_l;
    logic [LW-1:0] a_l, b_l, y_l, z_l, sum_l;
    logic [1:0]    cin_l;

    if (j == 0) begin : g_direct
      assign {mode_l, a_l, b_l} = {mode, a[LW-1:0], b[LW-1:0]};
      // A subtract forms -b as ~b + 1. The +1 enters here as the carry-in.
      assign cin_l = {1'b0, mode_l};
    end else begin : g_skew
      // Delay line of depth j for {mode, a limb, b limb}.
      logic [j-1:0][2*LW:0] sk_q;
      logic [j:0][2*LW:0]   sk_chain;
      assign sk_chain = {sk_q, {mode, a[j*LW +: LW], b[j*LW +: LW]}};
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sk_q <= '0;
        end else begin
          for (int d = 0; d < j; d++) begin
            if (en_chain[d]) sk_q[d] <= sk_chain[d];
          end
        end
      end
      assign {mode_l, a_l, b_l} = sk_chain[j];
      assign cin_l = carry[j-1];
    end

    assign y_l = (x25519_mode_t'(mode_l) == SUB) ? ~b_l : b_l;
    assign z_l = (x25519_mode_t'(mode_l) == SUB) ? BIAS[j*LW +: LW] : '0;

    x25519_limb_adder #(
      .LIMB_WIDTH(LW)
    ) u_adder (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en_chain[j]),
      .x        (a_l),
      .y        (y_l),
      .z        (z_l),
      .carry_in (cin_l),
      .sum      (sum_l),
      .carry_out(carry[j])
    );

    if (j == NUM_LIMBS - 1) begin : g_last
      assign res_limbs[j] = sum_l;
    end else begin : g_deskew
      // The limb finishes at stage j. Delay it by NUM_LIMBS-1-j so it lines up
      // with the top limb.
      localparam int D = NUM_LIMBS - 1 - j;
      logic [D-1:0][LW-1:0] ds_q;
      logic [D:0][LW-1:0]   ds_chain;
      assign ds_chain = {ds_q, sum_l};
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ds_q <= '0;
        end else begin
          for (int i = 0; i < D; i++) begin
            if (en_chain[j+1+i]) ds_q[i] <= ds_chain[i];
          end
        end
      end
      assign res_limbs[j] = ds_chain[D];
    end
  end

endmodule

// File: tb/tb_x25519_addsub_pipe.sv
// tb_x25519_addsub_pipe
//   Drives three configurations of the add/subtract pipe from one shared
//   stimulus stream: 4 limbs of 66 bits, 1 limb of 264 bits, 8 limbs of 33 bits.
//   Expected results come from plain modular arithmetic on 264-bit values.
//   Each op is queued with the cycle on which its result is due.
module tb_x25519_addsub_pipe;

  localparam int W  = 264;
  localparam int TW = 8;
  localparam int EW = 32 + TW + W;   // {due_cycle, tag, result}
  localparam logic [W-1:0] TWO_P = (264'd1 << 256) - 264'd38;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [W-1:0]  a, b;
  logic [TW-1:0] tag_in;

  logic          ov4, ov1, ov8;
  logic [W-1:0]  out4, out1, out8;
  logic [TW-1:0] tag4, tag1, tag8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic mon_on = 1'b0;

  logic [EW-1:0] exp_q4[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q8[$];
  logic [W-1:0]  last_res [3];
  logic [TW-1:0] last_tag [3];

  x25519_addsub_pipe dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .tag_in(tag_in),
    .out_valid(ov4), .out(out4), .tag_out(tag4)
  );

  x25519_addsub_pipe #(.LIMB_WIDTH(264)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .tag_in(tag_in),
    .out_valid(ov1), .out(out1), .tag_out(tag1)
  );

  x25519_addsub_pipe #(.LIMB_WIDTH(33)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .tag_in(tag_in),
    .out_valid(ov8), .out(out8), .tag_out(tag8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_calc(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    return m ? (x - y + TWO_P) : (x + y);
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] rand264();
    logic [W-1:0] r;
    r = rand256();
    r[263:256] = 8'($urandom);
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic m,
                      input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [TW-1:0] tg);
    logic [W-1:0] res;
    @(negedge clk);
    #1;
    rst_n  = r;
    en     = e;
    mode   = m;
    a      = aa;
    b      = bb;
    tag_in = tg;
    if (!r) begin
      exp_q4.delete();
      exp_q1.delete();
      exp_q8.delete();
      for (int i = 0; i < 3; i++) begin
        last_res[i] = '0;
        last_tag[i] = '0;
      end
    end else if (e) begin
      res = ref_calc(m, aa, bb);
      exp_q4.push_back({32'(cyc + 4), tg, res});
      exp_q1.push_back({32'(cyc + 1), tg, res});
      exp_q8.push_back({32'(cyc + 8), tg, res});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic op(input logic m, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [TW-1:0] tg);
    step(1'b1, 1'b1, m, aa, bb, tg);
  endtask

  // ---------------- scoreboard ----------------
  task automatic mon_one(input int id, input int lat, input logic ov,
                         input logic [W-1:0] o, input logic [TW-1:0] t);
    logic [EW-1:0] front;
    logic          have;
    logic          due_now;
    have  = 1'b0;
    front = '0;
    case (id)
      0: if (exp_q4.size() > 0) begin have = 1'b1; front = exp_q4[0]; end
      1: if (exp_q1.size() > 0) begin have = 1'b1; front = exp_q1[0]; end
      default: if (exp_q8.size() > 0) begin have = 1'b1; front = exp_q8[0]; end
    endcase
    due_now = have && (front[EW-1 -: 32] == 32'(cyc));

    checks++;
    assert (ov === due_now) else begin
      errors++;
      $error("FAIL valid lat%0d cyc %0d: out_valid=%b expected=%b", lat, cyc, ov, due_now);
    end

    if (due_now) begin
      case (id)
        0: void'(exp_q4.pop_front());
        1: void'(exp_q1.pop_front());
        default: void'(exp_q8.pop_front());
      endcase
      last_res[id] = front[W-1:0];
      last_tag[id] = front[W +: TW];
    end

    checks++;
    assert (o === last_res[id]) else begin
      errors++;
      $error("FAIL out lat%0d cyc %0d: got %h expected %h", lat, cyc, o, last_res[id]);
    end
    checks++;
    assert (t === last_tag[id]) else begin
      errors++;
      $error("FAIL tag lat%0d cyc %0d: got %h expected %h", lat, cyc, t, last_tag[id]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_one(0, 4, ov4, out4, tag4);
      mon_one(1, 1, ov1, out1, tag1);
      mon_one(2, 8, ov8, out8, tag8);
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    a      = '0;
    b      = '0;
    tag_in = '0;
    for (int i = 0; i < 3; i++) begin
      last_res[i] = '0;
      last_tag[i] = '0;
    end

    // Reset, with en high to show that it is ignored during reset.
    step(1'b0, 1'b1, 1'b1, rand256(), rand256(), 8'hAA);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    mon_on = 1'b1;
    idle(2);

    // Single subtract in isolation: all three latencies show up cleanly.
    op(1'b1, rand256(), rand256(), 8'h11);
    idle(9);

    // Boundary vectors.
    op(1'b1, 264'h1234, 264'h1234, 8'h21);                        // -> 2p
    op(1'b0, 264'd1, 264'd2, 8'h22);                              // -> 3
    op(1'b0, (264'd1 << 66) - 1, 264'd1, 8'h23);                  // carry across 66-bit limb
    op(1'b0, (264'd1 << 256) - 1, (264'd1 << 256) - 1, 8'h24);    // full ripple
    op(1'b0, (264'd1 << 33) - 1, 264'd1, 8'h25);                  // carry across 33-bit limb
    op(1'b1, 264'd0, (264'd1 << 256) - 1, 8'h26);                 // 0 - max + 2p
    op(1'b0, {W{1'b1}}, 264'd1, 8'h27);                           // wrap mod 2^264
    idle(9);

    // Streaming: 5 back-to-back ops with alternating mode, 2 bubbles, then 1 op.
    for (int i = 0; i < 5; i++) op(1'(i % 2), rand256(), rand256(), 8'(i));
    idle(2);
    op(1'b1, rand256(), rand256(), 8'd5);
    idle(9);

    // Reset mid-stream with ops in flight. en is high during the reset cycle.
    op(1'b0, rand256(), rand256(), 8'h31);
    op(1'b1, rand256(), rand256(), 8'h32);
    op(1'b0, rand256(), rand256(), 8'h33);
    step(1'b0, 1'b1, 1'b1, rand256(), rand256(), 8'h34);
    idle(2);
    op(1'b1, rand256(), rand256(), 8'h35);
    idle(9);

    // Random traffic: random bubbles, modes, tags; some full-width operands.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 3) == 0) op(1'($urandom), rand264(), rand264(), 8'($urandom));
        else                           op(1'($urandom), rand256(), rand256(), 8'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(10);

    // Every issued op must have emerged.
    checks++;
    assert (exp_q4.size() === 0) else begin
      errors++;
      $error("FAIL drain lat4: %0d results pending, expected 0", exp_q4.size());
    end
    checks++;
    assert (exp_q1.size() === 0) else begin
      errors++;
      $error("FAIL drain lat1: %0d results pending, expected 0", exp_q1.size());
    end
    checks++;
    assert (exp_q8.size() === 0) else begin
      errors++;
      $error("FAIL drain lat8: %0d results pending, expected 0", exp_q8.size());
    end

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
